// File: rtl/r0_cond_pkg.sv
// Shared definitions for the R0 condition evaluator: op codes, R0 flag bit
// positions (R0 is numbered [0:15], bit 0 is the MSB) and the FSM state type.
package r0_pkg;

    localparam logic [3:0] OP_UJ  = 4'd0;
    localparam logic [3:0] OP_JZ  = 4'd1;
    localparam logic [3:0] OP_JM  = 4'd2;
    localparam logic [3:0] OP_JN  = 4'd3;
    localparam logic [3:0] OP_JL  = 4'd4;
    localparam logic [3:0] OP_JE  = 4'd5;
    localparam logic [3:0] OP_JG  = 4'd6;
    localparam logic [3:0] OP_JYS = 4'd7;
    localparam logic [3:0] OP_JXS = 4'd8;
    localparam logic [3:0] OP_JVS = 4'd9;
    localparam logic [3:0] OP_JCS = 4'd10;
    localparam logic [3:0] OP_BLC = 4'd11;
    localparam logic [3:0] OP_BRC = 4'd12;

    localparam int R0_Z = 0;
    localparam int R0_M = 1;
    localparam int R0_V = 2;
    localparam int R0_C = 3;
    localparam int R0_L = 4;
    localparam int R0_E = 5;
    localparam int R0_G = 6;
    localparam int R0_Y = 7;
    localparam int R0_X = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_EVAL   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/r0_cond_if.sv
// Sequencer <-> condition evaluator bundle. The sequencer side (master)
// also forwards the live R0 contents.
interface r0_cond_if;
    logic [0:15] r0;
    logic        req;
    logic [3:0]  op;
    logic [0:7]  mask;
    logic        busy;
    logic        done;
    logic        take;
    logic        err;
    logic        clr_v;

    modport master (
        output r0, req, op, mask,
        input  busy, done, take, err, clr_v
    );

    modport slave (
        input  r0, req, op, mask,
        output busy, done, take, err, clr_v
    );
endinterface

// File: rtl/r0_cond_eval.sv
// Combinational condition decoder working on the R0 snapshot.
// BLC/BRC mask tests exist only when R0_COND_MASKTEST_EN is defined;
// otherwise ops 11 and 12 decode as illegal.
module r0_cond_eval
    import r0_pkg::*;
(
    input  logic [0:15] snap,
    input  logic [3:0]  op,
    input  logic [0:7]  mask,
    output logic        take,
    output logic        err,
    output logic        vhit
);

`ifndef R0_COND_MASKTEST_EN
    logic unused_mask;
    assign unused_mask = ^mask;
`endif

    // Decode the op against the snapshot flags.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        take = 1'b0;
        err  = 1'b0;
        vhit = 1'b0;
        case (op)
            OP_UJ:  take = 1'b1;
            OP_JZ:  take = snap[R0_Z];
            OP_JM:  take = snap[R0_M];
            OP_JN:  take = ~snap[R0_Z];
            OP_JL:  take = snap[R0_L];
            OP_JE:  take = snap[R0_E];
            OP_JG:  take = snap[R0_G];
            OP_JYS: take = snap[R0_Y];
            OP_JXS: take = snap[R0_X];
            OP_JVS: begin
                take = snap[R0_V];
                vhit = snap[R0_V];
            end
            OP_JCS: take = snap[R0_C];
`ifdef R0_COND_MASKTEST_EN
            OP_BLC: take = ((snap[0:7] & mask) == mask);
            OP_BRC: take = ((snap[8:15] & mask) == mask);
`endif
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/r0_cond.sv
// R0 condition evaluator: accepts a request, snapshots R0 one cycle later,
// registers the decision the cycle after that and strobes done (3-cycle
// latency). Optional BLC/BRC mask tests under R0_COND_MASKTEST_EN.
module r0_cond
    import r0_pkg::*;
(
    input  logic     clk_sys,
    input  logic     rst_,
    r0_cond_if.slave bus
);

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [0:15] snap_q, snap_d;
    logic        take_q, take_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        clr_v_q, clr_v_d;
    logic [0:7]  eval_mask;
    logic        eval_take, eval_err, eval_vhit;

`ifdef R0_COND_MASKTEST_EN
    logic [0:7]  mask_q, mask_d;
    assign eval_mask = mask_q;
`else
    logic unused_mask_in;
    assign unused_mask_in = ^bus.mask;
    assign eval_mask      = 8'h00;
`endif

    r0_cond_eval u_eval (
        .snap (snap_q),
        .op   (op_q),
        .mask (eval_mask),
        .take (eval_take),
        .err  (eval_err),
        .vhit (eval_vhit)
    );

    // Next-state and registered-output logic for IDLE/SAMPLE/EVAL/DONE.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        snap_d  = snap_q;
        take_d  = take_q;
        err_d   = err_q;
        done_d  = 1'b0;
        clr_v_d = 1'b0;
`ifdef R0_COND_MASKTEST_EN
        mask_d  = mask_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.req) begin
                    op_d    = bus.op;
`ifdef R0_COND_MASKTEST_EN
                    mask_d  = bus.mask;
`endif
                    state_d = ST_SAMPLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SAMPLE: begin
                snap_d  = bus.r0;
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
                take_d  = eval_take;
                err_d   = eval_err;
                clr_v_d = eval_vhit;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_SAMPLE) || (state_d == ST_EVAL);
    end

    // State and output registers with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_sys) begin
        if (!rst_) begin
            state_q <= ST_IDLE;
            op_q    <= 4'd0;
            snap_q  <= 16'h0000;
            take_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            clr_v_q <= 1'b0;
`ifdef R0_COND_MASKTEST_EN
            mask_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            snap_q  <= snap_d;
            take_q  <= take_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            clr_v_q <= clr_v_d;
`ifdef R0_COND_MASKTEST_EN
            mask_q  <= mask_d;
`endif
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.take  = take_q;
    assign bus.err   = err_q;
    assign bus.clr_v = clr_v_q;

endmodule

// File: doc/r0_cond.md
# r0_cond

Condition evaluator reading the processor state register R0 on behalf of conditional-jump and bit-test instructions (UJ, JZ, JM, JN, JL, JE, JG, JYS, JXS, JVS, JCS, BLC, BRC). The block sits downstream of R0, between R0 and the control sequencer. It takes a request from the sequencer, snapshots R0 after flag writes have settled, and evaluates the condition. It returns a take/no-take decision with a done pulse, plus a V-clear pulse back to R0's asynchronous V-clear input.

## Interface
Parameters: none.
- clk_sys  in  1  system clock; all state changes on rising edge
- rst_  in  1  synchronous, active-low reset
- r0  in  [0:15]  R0 contents, positive polarity: 0 Z, 1 M, 2 V, 3 C, 4 L, 5 E, 6 G, 7 Y, 8 X, 9..15 user bits
- req  in  1  evaluation request, sampled only when accepting
- op  in  4  condition code, latched with req
- mask  in  [0:7]  BLC/BRC mask, latched with req
- busy  out  1  high in SAMPLE and EVAL
- done  out  1  one-cycle result strobe
- take  out  1  condition result; valid when done=1, held until next acceptance
- err  out  1  illegal op; valid with done, held like take
- clr_v  out  1  one-cycle pulse requesting R0 V-flag clear

## Operation
- Op codes: 0 UJ (always), 1 JZ (Z), 2 JM (M), 3 JN (~Z), 4 JL (L), 5 JE (E), 6 JG (G), 7 JYS (Y), 8 JXS (X), 9 JVS (V), 10 JCS (C), 11 BLC, 12 BRC, 13..15 illegal.
- BLC: take = ((r0[0:7] & mask) == mask).
- BRC: take = ((r0[8:15] & mask) == mask).
- A zero mask gives take=1.
- FSM states: IDLE, SAMPLE, EVAL, DONE.
  - IDLE: if req=1, latch op and mask, then go to SAMPLE.
  - SAMPLE: capture r0 into a 16-bit snapshot, then go to EVAL.
  - EVAL: compute take and err into registers, then go to DONE.
  - DONE: done=1. If req=1, latch a new op and mask and go to SAMPLE; otherwise go to IDLE.
- req is ignored while busy=1; no queueing.
- Illegal op: take=0, err=1.
- clr_v: pulses in the DONE cycle only when op=JVS and snapshot V=1. take=1 in that case.
- Only the snapshot is evaluated. r0 changes after the SAMPLE edge do not affect the result.
- Reset (rst_=0 at any edge, including mid-operation): state returns to IDLE. busy, done, take, err and clr_v all go to 0; the snapshot and latched op clear to 0.

## Timing
- req accepted at edge N. Snapshot taken at edge N+1. Result registered at edge N+2.
- done, take, err and clr_v are visible after edge N+2 for one cycle. Latency: 3 cycles from req to done.
- Back-to-back throughput: one result every 3 cycles, with req held or re-asserted during DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- r0 must be stable during the cycle ending at edge N+1. The sequencer guarantees this by issuing req after the flag-write strobe (strob1).

## Configuration
- R0_COND_MASKTEST_EN defined: BLC and BRC are implemented as above.
- Macro undefined: ops 11 and 12 are treated as illegal (take=0, err=1). Mask latch and compare logic are removed; the mask input is ignored.

## Structure
- Shared package r0_pkg:
  - op-code constants (OP_UJ..OP_BRC);
  - flag bit-index constants (R0_Z=0 .. R0_X=8);
  - FSM state type.
- One sub-module, r0_cond_eval: purely combinational. Inputs: snapshot, op, mask. Outputs: take, err, vhit. The top holds the FSM and registers.

## Test plan
- Reset mid-EVAL: JZ with Z=1, assert rst_=0 during EVAL. Required: no done; all outputs 0 next cycle; a subsequent req is accepted normally.
- JZ, r0=16'h8000: done at N+3 with take=1, err=0. Repeat with r0=16'h0000 and op=JN: take=1.
- JVS, r0=16'h2000: take=1 and clr_v=1 in the done cycle. With r0=16'h0000: take=0, clr_v=0.
- Snapshot isolation: JG with r0=16'h0200 at SAMPLE, r0 changed to 0 during EVAL. Required: take=1.
- With R0_COND_MASKTEST_EN: BLC, mask 8'hA0, r0=16'hA000 gives take=1; r0=16'h8000 gives take=0. BRC, mask 8'h01, r0=16'h0001 gives take=1. Without the macro: both give err=1, take=0.
- Back-to-back: req held high with op=UJ, then JCS (C=0), then op=14. Required: done every 3 cycles; take 1,0,0; err 0,0,1; req during busy ignored.
